// File: rtl/hack_mmio_pkg.sv
// Shared types and address-map helpers for the HACK memory-mapped I/O controller.
// The region map is RAM at zero, then the screen window, then a single keyboard word.
package hack_mmio_pkg;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_SCR,
      REG_KBD,
      REG_ILL
   } region_e;

   localparam int DEF_DW        = 16;
   localparam int DEF_AW        = 15;
   localparam int DEF_RAM_AW    = 14;
   localparam int DEF_SCR_AW    = 13;
   localparam int DEF_KBD_DEPTH = 8;

   function automatic int scr_base(input int ram_aw);
      return 1 << ram_aw;
   endfunction

   function automatic int kbd_addr(input int ram_aw, input int scr_aw);
      return (1 << ram_aw) + (1 << scr_aw);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push, pop and flush, exposing the head word and occupancy.
// DEPTH must be a power of two (at least 2) so the pointers wrap on their own.
module sync_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   input  logic          flush,
   output logic [DW-1:0] head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
   always_comb begin
      do_pop   = pop && (count_q != '0) && !flush;
      do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/hack_mmio.sv
// HACK CPU data-port controller: address decode, RAM/screen strobes, registered read
// return with a valid pulse, a buffered keyboard FIFO and sticky error flags.
module hack_mmio
   import hack_mmio_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int RAM_AW    = DEF_RAM_AW,
   parameter int SCR_AW    = DEF_SCR_AW,
   parameter int KBD_DEPTH = DEF_KBD_DEPTH,
   localparam int CW       = $clog2(KBD_DEPTH) + 1
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic [AW-1:0]     addressM,
   input  logic [DW-1:0]     dataM,
   input  logic              writeM,
   input  logic              readM,
   output logic [DW-1:0]     Q,
   output logic              q_valid,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_d,
   output logic              ram_we,
   input  logic [DW-1:0]     ram_q,
   output logic [SCR_AW-1:0] scr_addr,
   output logic              scr_we,
   input  logic [DW-1:0]     scr_q,
   input  logic [DW-1:0]     kbd_code,
   input  logic              kbd_push,
   output logic [CW-1:0]     kbd_count,
   output logic              kbd_full,
   output logic              err_addr,
   output logic              kbd_ovf,
   input  logic              err_clr
);

   localparam logic [AW-1:0] SCR_BASE = AW'(scr_base(RAM_AW));
   localparam logic [AW-1:0] KBD_A    = AW'(kbd_addr(RAM_AW, SCR_AW));

   region_e       region;
   region_e       sel_q, sel_d;
   logic          q_valid_q, q_valid_d;
   logic [DW-1:0] q_hold_q, q_hold_d;
   logic [DW-1:0] kbd_data_q, kbd_data_d;
   logic          err_addr_q, err_addr_d;
   logic          kbd_ovf_q, kbd_ovf_d;
   logic [DW-1:0] rd_mux;
   logic          rd_req;
   logic          kbd_pop;
   logic          kbd_flush;
   logic          kbd_empty;
   logic [DW-1:0] kbd_head;

   always_comb begin
      if (addressM < SCR_BASE)   region = REG_RAM;
      else if (addressM < KBD_A) region = REG_SCR;
      else if (addressM == KBD_A) region = REG_KBD;
      else                        region = REG_ILL;
   end

   // A simultaneous write and read performs only the write.
   always_comb begin
      rd_req    = readM && !writeM;
      ram_we    = writeM && (region == REG_RAM);
      scr_we    = writeM && (region == REG_SCR);
      kbd_flush = writeM && (region == REG_KBD);
      kbd_pop   = rd_req && (region == REG_KBD) && !kbd_empty;
   end

   always_comb begin
      sel_d      = rd_req ? region : sel_q;
      q_valid_d  = rd_req;
      kbd_data_d = kbd_data_q;
      if (rd_req && (region == REG_KBD)) kbd_data_d = kbd_empty ? '0 : kbd_head;

      case (sel_q)
         REG_RAM: rd_mux = ram_q;
         REG_SCR: rd_mux = scr_q;
         REG_KBD: rd_mux = kbd_data_q;
         default: rd_mux = '0;
      endcase
      q_hold_d = q_valid_q ? rd_mux : q_hold_q;

      // A flag being set in the same cycle as err_clr stays set.
      err_addr_d = ((writeM || readM) && (region == REG_ILL)) || (err_addr_q && !err_clr);
      kbd_ovf_d  = (kbd_push && kbd_full && !kbd_pop && !kbd_flush) || (kbd_ovf_q && !err_clr);
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         sel_q      <= REG_ILL;
         q_valid_q  <= 1'b0;
         q_hold_q   <= '0;
         kbd_data_q <= '0;
         err_addr_q <= 1'b0;
         kbd_ovf_q  <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         q_valid_q  <= q_valid_d;
         q_hold_q   <= q_hold_d;
         kbd_data_q <= kbd_data_d;
         err_addr_q <= err_addr_d;
         kbd_ovf_q  <= kbd_ovf_d;
      end
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (KBD_DEPTH)
   ) u_kbd_fifo (
      .clk   (clk1),
      .rst   (rst),
      .push  (kbd_push),
      .din   (kbd_code),
      .pop   (kbd_pop),
      .flush (kbd_flush),
      .head  (kbd_head),
      .count (kbd_count),
      .full  (kbd_full),
      .empty (kbd_empty)
   );

   assign Q        = q_valid_q ? rd_mux : q_hold_q;
   assign q_valid  = q_valid_q;
   assign ram_addr = addressM[RAM_AW-1:0];
   assign ram_d    = dataM;
   assign scr_addr = addressM[SCR_AW-1:0];
   assign err_addr = err_addr_q;
   assign kbd_ovf  = kbd_ovf_q;

endmodule
